// File: rtl/ifm_window_addr_gen.sv
// Sliding-window read-address generator for an IFM buffer: walks oy/ox/c/ky/kx and
// emits one address beat per handshake, flagging zero-pad positions outside the map.
module ifm_window_addr_gen #(
   parameter int KERNEL_SIZE = 3,
   parameter int IFM_SIZE    = 416,
   parameter int IFM_CHANNEL = 3,
   parameter int ADDR_WIDTH  = 19,
   parameter int STRIDE      = 1,
   parameter int PAD         = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  addr_ready,
   output logic [ADDR_WIDTH-1:0] ifm_addr,
   output logic                  addr_valid,
   output logic                  pad_flag,
   output logic                  win_last,
   output logic                  addr_last,
   output logic                  busy,
   output logic                  done
);

   // state  | meaning
   // S_IDLE | waiting for load, no beats
   // S_RUN  | presenting beats, counters advance on handshake
   // S_DONE | one-cycle completion pulse, returns to idle
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam int OFM_SIZE = (IFM_SIZE + 2*PAD - KERNEL_SIZE) / STRIDE + 1;
   localparam int OW = $clog2(OFM_SIZE + 1);
   localparam int CW = $clog2(IFM_CHANNEL + 1);
   localparam int KW = $clog2(KERNEL_SIZE + 1);
   localparam int SW = ADDR_WIDTH + 2;

   localparam logic [OW-1:0] O_LAST = OW'(OFM_SIZE - 1);
   localparam logic [CW-1:0] C_LAST = CW'(IFM_CHANNEL - 1);
   localparam logic [KW-1:0] K_LAST = KW'(KERNEL_SIZE - 1);

   localparam logic signed [SW-1:0] S_PAD     = SW'(PAD);
   localparam logic signed [SW-1:0] S_KM1     = SW'(KERNEL_SIZE - 1);
   localparam logic signed [SW-1:0] S_STR     = SW'(STRIDE);
   localparam logic signed [SW-1:0] S_IFM     = SW'(IFM_SIZE);
   localparam logic signed [SW-1:0] S_KM1_ROW = SW'((KERNEL_SIZE - 1) * IFM_SIZE);
   localparam logic signed [SW-1:0] S_STR_ROW = SW'(STRIDE * IFM_SIZE);
   localparam logic signed [SW-1:0] S_PAD_ROW = SW'(PAD * IFM_SIZE);
   localparam logic [ADDR_WIDTH-1:0] PLANE    = ADDR_WIDTH'(IFM_SIZE * IFM_SIZE);

   state_t state_q, state_d;

   logic [OW-1:0] oy_q, oy_d, ox_q, ox_d, n_oy, n_ox, b_oy, b_ox;
   logic [CW-1:0] c_q, c_d, n_c, b_c;
   logic [KW-1:0] ky_q, ky_d, kx_q, kx_d, n_ky, n_kx, b_ky, b_kx;
   // row/col are the signed map coordinates of the current tap; roff tracks row*IFM_SIZE
   logic signed [SW-1:0] row_q, row_d, col_q, col_d, roff_q, roff_d;
   logic signed [SW-1:0] n_row, n_col, n_roff, b_row, b_col, b_roff;
   logic [ADDR_WIDTH-1:0] coff_q, coff_d, n_coff, b_coff;

   logic [ADDR_WIDTH-1:0] ifm_addr_q, ifm_addr_d;
   logic addr_valid_q, addr_valid_d, pad_flag_q, pad_flag_d;
   logic win_last_q, win_last_d, addr_last_q, addr_last_d;
   logic busy_q, busy_d, done_q, done_d;

   logic                  b_in_map, b_win_last, b_addr_last;
   logic signed [SW-1:0]  b_addr_s;

   always_comb begin
      n_oy = oy_q; n_ox = ox_q; n_c = c_q; n_ky = ky_q; n_kx = kx_q;
      n_row = row_q; n_col = col_q; n_roff = roff_q; n_coff = coff_q;
      if (kx_q != K_LAST) begin
         n_kx  = kx_q + KW'(1);
         n_col = col_q + SW'(1);
      end else begin
         n_kx  = '0;
         n_col = col_q - S_KM1;
         if (ky_q != K_LAST) begin
            n_ky   = ky_q + KW'(1);
            n_row  = row_q + SW'(1);
            n_roff = roff_q + S_IFM;
         end else begin
            n_ky   = '0;
            n_row  = row_q - S_KM1;
            n_roff = roff_q - S_KM1_ROW;
            if (c_q != C_LAST) begin
               n_c    = c_q + CW'(1);
               n_coff = coff_q + PLANE;
            end else begin
               n_c    = '0;
               n_coff = '0;
               if (ox_q != O_LAST) begin
                  n_ox  = ox_q + OW'(1);
                  n_col = col_q - S_KM1 + S_STR;
               end else begin
                  n_ox  = '0;
                  n_col = -S_PAD;
                  if (oy_q != O_LAST) begin
                     n_oy   = oy_q + OW'(1);
                     n_row  = row_q - S_KM1 + S_STR;
                     n_roff = roff_q - S_KM1_ROW + S_STR_ROW;
                  end else begin
                     n_oy   = '0;
                     n_row  = -S_PAD;
                     n_roff = -S_PAD_ROW;
                  end
               end
            end
         end
      end
   end

   // beat source: origin of the map when starting, otherwise the advanced counters
   always_comb begin
      b_oy = n_oy; b_ox = n_ox; b_c = n_c; b_ky = n_ky; b_kx = n_kx;
      b_row = n_row; b_col = n_col; b_roff = n_roff; b_coff = n_coff;
      if (state_q == S_IDLE) begin
         b_oy = '0; b_ox = '0; b_c = '0; b_ky = '0; b_kx = '0;
         b_row = -S_PAD; b_col = -S_PAD; b_roff = -S_PAD_ROW; b_coff = '0;
      end
   end

   always_comb begin
      b_in_map    = (b_row >= 0) && (b_row < S_IFM) && (b_col >= 0) && (b_col < S_IFM);
      b_addr_s    = $signed({2'b00, b_coff}) + b_roff + b_col;
      b_win_last  = (b_c == C_LAST) && (b_ky == K_LAST) && (b_kx == K_LAST);
      b_addr_last = b_win_last && (b_oy == O_LAST) && (b_ox == O_LAST);
   end

   always_comb begin
      state_d      = state_q;
      oy_d = oy_q; ox_d = ox_q; c_d = c_q; ky_d = ky_q; kx_d = kx_q;
      row_d = row_q; col_d = col_q; roff_d = roff_q; coff_d = coff_q;
      ifm_addr_d   = ifm_addr_q;
      addr_valid_d = addr_valid_q;
      pad_flag_d   = pad_flag_q;
      win_last_d   = win_last_q;
      addr_last_d  = addr_last_q;
      case (state_q)
         S_IDLE: if (load) state_d = S_RUN;
         S_RUN:  if (addr_valid_q && addr_ready && addr_last_q) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      if ((state_q == S_IDLE && load) ||
          (state_q == S_RUN && addr_valid_q && addr_ready && !addr_last_q)) begin
         oy_d = b_oy; ox_d = b_ox; c_d = b_c; ky_d = b_ky; kx_d = b_kx;
         row_d = b_row; col_d = b_col; roff_d = b_roff; coff_d = b_coff;
         ifm_addr_d   = b_in_map ? b_addr_s[ADDR_WIDTH-1:0] : '0;
         addr_valid_d = 1'b1;
         pad_flag_d   = !b_in_map;
         win_last_d   = b_win_last;
         addr_last_d  = b_addr_last;
      end else if (state_d != S_RUN) begin
         ifm_addr_d   = '0;
         addr_valid_d = 1'b0;
         pad_flag_d   = 1'b0;
         win_last_d   = 1'b0;
         addr_last_d  = 1'b0;
      end
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         oy_q <= '0; ox_q <= '0; c_q <= '0; ky_q <= '0; kx_q <= '0;
         row_q <= '0; col_q <= '0; roff_q <= '0; coff_q <= '0;
         ifm_addr_q   <= '0;
         addr_valid_q <= 1'b0;
         pad_flag_q   <= 1'b0;
         win_last_q   <= 1'b0;
         addr_last_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         oy_q <= oy_d; ox_q <= ox_d; c_q <= c_d; ky_q <= ky_d; kx_q <= kx_d;
         row_q <= row_d; col_q <= col_d; roff_q <= roff_d; coff_q <= coff_d;
         ifm_addr_q   <= ifm_addr_d;
         addr_valid_q <= addr_valid_d;
         pad_flag_q   <= pad_flag_d;
         win_last_q   <= win_last_d;
         addr_last_q  <= addr_last_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign ifm_addr   = ifm_addr_q;
   assign addr_valid = addr_valid_q;
   assign pad_flag   = pad_flag_q;
   assign win_last   = win_last_q;
   assign addr_last  = addr_last_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_ifm_window_addr_gen.sv
// Directed bench for ifm_window_addr_gen: a padded stride-1 map (A) and an
// unpadded stride-2 map (B), with ready throttling, reset mid-run and stray loads.
module tb_ifm_window_addr_gen;

   logic clk = 1'b0;
   logic rst, load, ready;

   logic [18:0] a_addr, b_addr;
   logic a_valid, a_pad, a_wl, a_al, a_busy, a_done;
   logic b_valid, b_pad, b_wl, b_al, b_busy, b_done;

   ifm_window_addr_gen #(.KERNEL_SIZE(3), .IFM_SIZE(4), .IFM_CHANNEL(2), .ADDR_WIDTH(19),
                         .STRIDE(1), .PAD(1)) u_a (
      .clk(clk), .rst(rst), .load(load), .addr_ready(ready),
      .ifm_addr(a_addr), .addr_valid(a_valid), .pad_flag(a_pad), .win_last(a_wl),
      .addr_last(a_al), .busy(a_busy), .done(a_done));

   ifm_window_addr_gen #(.KERNEL_SIZE(3), .IFM_SIZE(5), .IFM_CHANNEL(1), .ADDR_WIDTH(19),
                         .STRIDE(2), .PAD(0)) u_b (
      .clk(clk), .rst(rst), .load(load), .addr_ready(ready),
      .ifm_addr(b_addr), .addr_valid(b_valid), .pad_flag(b_pad), .win_last(b_wl),
      .addr_last(b_al), .busy(b_busy), .done(b_done));

   always #5 clk = ~clk;

   bit sel;
   logic [18:0] o_addr;
   logic o_valid, o_pad, o_wl, o_al, o_busy, o_done;
   always_comb begin
      o_addr  = sel ? b_addr  : a_addr;
      o_valid = sel ? b_valid : a_valid;
      o_pad   = sel ? b_pad   : a_pad;
      o_wl    = sel ? b_wl    : a_wl;
      o_al    = sel ? b_al    : a_al;
      o_busy  = sel ? b_busy  : a_busy;
      o_done  = sel ? b_done  : a_done;
   end

   int checks = 0;
   int failures = 0;

   int cap_addr [0:399];
   bit cap_pad  [0:399];
   bit cap_wl   [0:399];
   bit cap_al   [0:399];
   int cap_n, hold_err, done_cnt, done_at, last_at, valid_after_done;
   bit timeout, first_valid, first_busy;

   task automatic step();
      @(posedge clk); #1;
   endtask

   function automatic void model(input int k, input int isz, input int ch, input int st,
                                 input int pd, input int idx, output int addr,
                                 output bit pad, output bit wl, output bit al);
      int ofm, kx, ky, c, ox, oy, row, col, r;
      ofm = (isz + 2*pd - k) / st + 1;
      r = idx;
      kx = r % k; r = r / k;
      ky = r % k; r = r / k;
      c  = r % ch; r = r / ch;
      ox = r % ofm; oy = r / ofm;
      row = oy*st + ky - pd;
      col = ox*st + kx - pd;
      pad = !(row >= 0 && row < isz && col >= 0 && col < isz);
      addr = pad ? 0 : c*isz*isz + row*isz + col;
      wl = (c == ch-1) && (ky == k-1) && (kx == k-1);
      al = wl && (oy == ofm-1) && (ox == ofm-1);
   endfunction

   task automatic do_reset();
      rst = 1'b1; load = 1'b0; ready = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   // Pulses load, then records accepted beats of the selected instance until done settles.
   task automatic capture(input bit which, input bit rnd, input bit poke_load, input int stop_after);
      bit held, fin;
      logic [18:0] s_addr;
      logic s_valid, s_pad, s_wl, s_al;
      sel = which;
      cap_n = 0; hold_err = 0; done_cnt = 0; done_at = -1; last_at = -2;
      valid_after_done = 0; held = 1'b0; fin = 1'b0;
      s_addr = '0; s_valid = 1'b0; s_pad = 1'b0; s_wl = 1'b0; s_al = 1'b0;
      load = 1'b1;
      step();
      load = 1'b0;
      first_valid = o_valid;
      first_busy  = o_busy;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (held && ({o_addr, o_valid, o_pad, o_wl, o_al} !== {s_addr, s_valid, s_pad, s_wl, s_al}))
            hold_err++;
         if (o_done) begin
            done_cnt++;
            done_at = cyc;
         end
         if (done_cnt > 0 && o_valid) valid_after_done++;
         if (stop_after > 0 && cap_n == stop_after) begin
            fin = 1'b1;
            break;
         end
         ready = rnd ? 1'(($urandom_range(0, 3) != 0) ? 1 : 0) : 1'b1;
         load = poke_load && (o_done || (o_valid && ready && o_al) || cyc == 20);
         if (o_valid && ready) begin
            if (cap_n < 400) begin
               cap_addr[cap_n] = int'(o_addr);
               cap_pad[cap_n]  = o_pad;
               cap_wl[cap_n]   = o_wl;
               cap_al[cap_n]   = o_al;
            end
            cap_n++;
            if (o_al) last_at = cyc;
         end
         held = o_valid && !ready;
         s_addr = o_addr; s_valid = o_valid; s_pad = o_pad; s_wl = o_wl; s_al = o_al;
         if (done_cnt > 0 && cyc >= done_at + 4) begin
            fin = 1'b1;
            break;
         end
         step();
      end
      load = 1'b0;
      ready = 1'b1;
      timeout = !fin;
   endtask

   task automatic check_sequence(input bit which, input int total, input string tag);
      int ea; bit ep, ew, el;
      for (int i = 0; i < total && i < cap_n && i < 400; i++) begin
         if (which) model(3, 5, 1, 2, 0, i, ea, ep, ew, el);
         else       model(3, 4, 2, 1, 1, i, ea, ep, ew, el);
         checks++;
         if ({cap_addr[i], cap_pad[i], cap_wl[i], cap_al[i]} !== {ea, ep, ew, el}) begin
            failures++;
            $display("FAIL %s beat %0d: got addr=%0d pad=%0b wl=%0b al=%0b, want addr=%0d pad=%0b wl=%0b al=%0b",
                     tag, i, cap_addr[i], cap_pad[i], cap_wl[i], cap_al[i], ea, ep, ew, el);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; ready = 1'b1;
      step(); step();
      checks++;
      if ({a_addr, a_valid, a_pad, a_wl, a_al, a_busy, a_done} !== 25'd0) begin
         failures++;
         $display("FAIL reset_a: got %h, want 0", {a_addr, a_valid, a_pad, a_wl, a_al, a_busy, a_done});
      end
      checks++;
      if ({b_addr, b_valid, b_pad, b_wl, b_al, b_busy, b_done} !== 25'd0) begin
         failures++;
         $display("FAIL reset_b: got %h, want 0", {b_addr, b_valid, b_pad, b_wl, b_al, b_busy, b_done});
      end
      rst = 1'b0;
      step(); step();
      checks++;
      if ({a_valid, a_busy, a_done} !== 3'b000) begin
         failures++;
         $display("FAIL idle_no_load: got valid/busy/done=%b, want 000", {a_valid, a_busy, a_done});
      end
   endtask

   task automatic test_full_run_a();
      do_reset();
      capture(1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (timeout !== 1'b0) begin failures++; $display("FAIL run_a_timeout: got 1, want 0"); end
      checks++;
      if ({first_valid, first_busy} !== 2'b11) begin
         failures++; $display("FAIL run_a_first_beat: got valid/busy=%b, want 11", {first_valid, first_busy});
      end
      checks++;
      if (cap_n !== 288) begin failures++; $display("FAIL run_a_count: got %0d, want 288", cap_n); end
      checks++;
      if (done_cnt !== 1) begin failures++; $display("FAIL run_a_done_pulses: got %0d, want 1", done_cnt); end
      checks++;
      if (done_at !== last_at + 1) begin
         failures++; $display("FAIL run_a_done_timing: got done at %0d, want %0d", done_at, last_at + 1);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_pad[i] !== 1'b1 || cap_addr[i] !== 0) begin
            failures++; $display("FAIL run_a_lead_pad beat %0d: got pad=%0b addr=%0d, want pad=1 addr=0", i+1, cap_pad[i], cap_addr[i]);
         end
      end
      checks++;
      if (cap_pad[4] !== 1'b0 || cap_addr[4] !== 0) begin
         failures++; $display("FAIL run_a_beat5: got pad=%0b addr=%0d, want pad=0 addr=0", cap_pad[4], cap_addr[4]);
      end
      check_sequence(1'b0, 288, "run_a_seq");
   endtask

   // window oy=ox=3, c=1 occupies beats 279..287 of run A
   task automatic test_last_window_a();
      checks++;
      if (cap_addr[283] !== 31 || cap_pad[283] !== 1'b0) begin
         failures++; $display("FAIL last_win_center: got addr=%0d pad=%0b, want addr=31 pad=0", cap_addr[283], cap_pad[283]);
      end
      for (int i = 284; i < 288; i++) begin
         checks++;
         if (cap_pad[i] !== 1'b1) begin
            failures++; $display("FAIL last_win_pad beat %0d: got %0b, want 1", i, cap_pad[i]);
         end
      end
      checks++;
      if ({cap_wl[287], cap_al[287], cap_al[286]} !== 3'b110) begin
         failures++; $display("FAIL last_win_flags: got wl,al,prev_al=%b, want 110", {cap_wl[287], cap_al[287], cap_al[286]});
      end
   endtask

   task automatic test_stride2_b();
      int exp_w [0:8] = '{2, 3, 4, 7, 8, 9, 12, 13, 14};
      do_reset();
      capture(1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (timeout !== 1'b0 || cap_n !== 36) begin
         failures++; $display("FAIL run_b_count: got %0d (timeout=%0b), want 36", cap_n, timeout);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (cap_addr[9+i] !== exp_w[i] || cap_pad[9+i] !== 1'b0 || cap_wl[9+i] !== (i == 8)) begin
            failures++; $display("FAIL run_b_window tap %0d: got addr=%0d pad=%0b wl=%0b, want addr=%0d pad=0 wl=%0b",
                                 i, cap_addr[9+i], cap_pad[9+i], cap_wl[9+i], exp_w[i], (i == 8));
         end
      end
      checks++;
      if (done_cnt !== 1) begin failures++; $display("FAIL run_b_done_pulses: got %0d, want 1", done_cnt); end
      check_sequence(1'b1, 36, "run_b_seq");
   endtask

   task automatic test_random_ready();
      do_reset();
      capture(1'b0, 1'b1, 1'b0, 0);
      checks++;
      if (timeout !== 1'b0 || cap_n !== 288) begin
         failures++; $display("FAIL rand_ready_count: got %0d (timeout=%0b), want 288", cap_n, timeout);
      end
      checks++;
      if (hold_err !== 0) begin failures++; $display("FAIL rand_ready_hold: got %0d changes while stalled, want 0", hold_err); end
      check_sequence(1'b0, 288, "rand_ready_seq");
   endtask

   task automatic test_reset_midrun();
      int ea; bit ep, ew, el;
      do_reset();
      capture(1'b0, 1'b0, 1'b0, 99);
      model(3, 4, 2, 1, 1, 99, ea, ep, ew, el);
      checks++;
      if (o_valid !== 1'b1 || int'(o_addr) !== ea || o_pad !== ep) begin
         failures++; $display("FAIL midrun_beat100: got valid=%0b addr=%0d pad=%0b, want valid=1 addr=%0d pad=%0b", o_valid, o_addr, o_pad, ea, ep);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({a_addr, a_valid, a_pad, a_wl, a_al, a_busy, a_done} !== 25'd0) begin
         failures++; $display("FAIL midrun_reset_outputs: got %h, want 0", {a_addr, a_valid, a_pad, a_wl, a_al, a_busy, a_done});
      end
      rst = 1'b0;
      step(); step();
      checks++;
      if ({a_valid, a_busy} !== 2'b00) begin
         failures++; $display("FAIL midrun_no_resume: got valid/busy=%b, want 00", {a_valid, a_busy});
      end
      capture(1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (timeout !== 1'b0 || cap_n !== 288) begin
         failures++; $display("FAIL midrun_restart_count: got %0d (timeout=%0b), want 288", cap_n, timeout);
      end
      check_sequence(1'b0, 288, "midrun_restart_seq");
   endtask

   task automatic test_load_ignored();
      do_reset();
      capture(1'b0, 1'b0, 1'b1, 0);
      checks++;
      if (timeout !== 1'b0 || cap_n !== 288) begin
         failures++; $display("FAIL stray_load_count: got %0d (timeout=%0b), want 288", cap_n, timeout);
      end
      checks++;
      if (done_cnt !== 1) begin failures++; $display("FAIL stray_load_done_pulses: got %0d, want 1", done_cnt); end
      checks++;
      if (valid_after_done !== 0) begin
         failures++; $display("FAIL stray_load_restart: got %0d valid cycles after done, want 0", valid_after_done);
      end
      check_sequence(1'b0, 288, "stray_load_seq");
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; ready = 1'b1; sel = 1'b0;
      test_reset();
      test_full_run_a();
      test_last_window_a();
      test_stride2_b();
      test_random_ready();
      test_reset_midrun();
      test_load_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
